// File: rtl/bsg_print_stat_event_buffer.sv
// bsg_print_stat_event_buffer: timestamps print_stat strobes, pairs start/end
// tags into region cycle counts, and queues events for a valid/yumi consumer.
module bsg_print_stat_event_buffer #(
    parameter int data_width_p     = 32,
    parameter int ctr_width_p      = 64,
    parameter int els_p            = 8,
    parameter int drop_ctr_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        print_stat_v_i,
    input  logic [data_width_p-1:0]     print_stat_tag_i,
    input  logic [ctr_width_p-1:0]      global_ctr_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [1:0]                  kind_o,
    output logic [data_width_p-1:0]     tag_o,
    output logic [ctr_width_p-1:0]      cycle_o,
    output logic [ctr_width_p-1:0]      delta_o,
    output logic                        region_open_o,
    output logic [drop_ctr_width_p-1:0] dropped_o,
    output logic                        err_nested_o,
    output logic                        err_unmatched_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int ent_w_lp = 2 + data_width_p + 2 * ctr_width_p;
    localparam logic [1:0] kind_start_lp = 2'd1;
    localparam logic [1:0] kind_end_lp   = 2'd2;
    localparam logic [0:0] idle_lp = 1'b0;
    localparam logic [0:0] open_lp = 1'b1;

    logic [ent_w_lp-1:0]         mem_q [els_p];
    logic [ptr_w_lp-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;
    logic [0:0]                  state_q, state_d;
    logic [ctr_width_p-1:0]      start_cycle_q, start_cycle_d;
    logic [drop_ctr_width_p-1:0] dropped_q, dropped_d;
    logic                        err_nested_q, err_nested_d;
    logic                        err_unmatched_q, err_unmatched_d;
    logic [1:0]                  kind;
    logic [ctr_width_p-1:0]      delta;
    logic                        full, pop, push, is_start, is_end;

    assign kind     = print_stat_tag_i[data_width_p-1:data_width_p-2];
    assign is_start = print_stat_v_i && kind == kind_start_lp;
    assign is_end   = print_stat_v_i && kind == kind_end_lp;
    assign full     = count_q == cnt_w_lp'(els_p);
    assign v_o      = count_q != '0;
    // A pop frees the slot this same edge, so a push to a full FIFO with yumi is kept.
    assign pop      = yumi_i && v_o;
    assign push     = print_stat_v_i && (!full || pop);
    assign delta    = (is_end && state_q == open_lp) ? global_ctr_i - start_cycle_q : '0;

    always_comb begin
        wr_ptr_d        = push ? wr_ptr_q + ptr_w_lp'(1) : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + ptr_w_lp'(1) : rd_ptr_q;
        count_d         = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
        dropped_d       = (print_stat_v_i && !push && !(&dropped_q)) ? dropped_q + 1'b1 : dropped_q;
        state_d         = is_start ? open_lp : is_end ? idle_lp : state_q;
        start_cycle_d   = is_start ? global_ctr_i : start_cycle_q;
        err_nested_d    = err_nested_q || (is_start && state_q == open_lp);
        err_unmatched_d = err_unmatched_q || (is_end && state_q == idle_lp);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= idle_lp;
            start_cycle_q   <= '0;
            dropped_q       <= '0;
            err_nested_q    <= 1'b0;
            err_unmatched_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            start_cycle_q   <= start_cycle_d;
            dropped_q       <= dropped_d;
            err_nested_q    <= err_nested_d;
            err_unmatched_q <= err_unmatched_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {kind, print_stat_tag_i, global_ctr_i, delta};
    end

    assign {kind_o, tag_o, cycle_o, delta_o} = mem_q[rd_ptr_q];
    assign region_open_o   = state_q == open_lp;
    assign dropped_o       = dropped_q;
    assign err_nested_o    = err_nested_q;
    assign err_unmatched_o = err_unmatched_q;

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o=0");
endmodule
